cp_bypass_net: RTL and testbench
================================

// Module: cp_bypass_net
// PURPOSE
//  Parametrised successor of the CP operand-bypass stage. Forwards RF write-back data from NUM_SRC
//  pipeline stages to NUM_RD read ports. Adds a retire shadow register for the synchronous-read RF
//  and a load-use interlock FSM that stalls IF/ID until forwarded load data is ready. Also adds a
//  registered long-immediate prefix. Sits between IF/RF read and ID; operand outputs feed the ALU.
// PARAMETERS
//  DATA_W    32  datapath width
//  ADDR_W    5   RF index width; register 0 is hard-wired zero and is never forwarded
//  NUM_SRC   3   forwarding sources; index 0 = youngest (EX), NUM_SRC-1 = oldest (WB)
//  NUM_RD    2   read ports; port 1 carries the immediate/RSUBI swap
//  IMM_W     16  short-immediate width; long-immediate prefix is DATA_W-IMM_W bits
//  STALL_MAX 7   max consecutive interlock cycles before oStall_Timeout; >=1
// PORTS
//  iClk              in  1                  clock, all state on rising edge
//  iReset            in  1                  synchronous, active-high reset
//  iSrc_Addr         in  NUM_SRC*ADDR_W     write address per source, packed, src0 in LSBs
//  iSrc_Data         in  NUM_SRC*DATA_W     write data per source
//  iSrc_Write_Enable in  NUM_SRC            write enable per source
//  iSrc_Ready        in  NUM_SRC            1 = data valid now; 0 = pending load result
//  iRd_Addr          in  NUM_RD*ADDR_W      read addresses from IF
//  iRF_Data          in  NUM_RD*DATA_W      RF read data; valid one cycle after the RF write edge
//  iSelect_Imm       in  1                  operand B from immediate
//  iImm              in  DATA_W             sign-extended short immediate
//  iLimm_Valid       in  1                  current instruction is a long-imm prefix
//  iLimm_Value       in  DATA_W-IMM_W       prefix bits
//  iIs_SUB           in  1                  SUB opcode; with iSelect_Imm means RSUBI
//  iAdvance          in  1                  ID consumes the current instruction this cycle
//  oOperand          out NUM_RD*DATA_W      resolved operands after mux, imm select and swap
//  oStore_Data       out DATA_W             port-1 bypassed value, before the immediate mux
//  oStall            out 1                  interlock, holds IF/ID
//  oStall_Timeout    out 1                  sticky; interlock exceeded STALL_MAX
// BEHAVIOUR
//  Forwarding (combinational), per port p:
//  - First match wins, searched from the youngest source.
//  - Source s matches when iRd_Addr[p]==iSrc_Addr[s], iRd_Addr[p]!=0 and iSrc_Write_Enable[s].
//  - With no source match, use the shadow if its valid bit is set and shadow addr==iRd_Addr[p].
//  - Otherwise use iRF_Data[p].
//  Retire shadow:
//  - Each cycle captures {addr, data, valid} from source NUM_SRC-1.
//  - valid = enable & (addr!=0).
//  - Reset clears valid to 0; it is never cleared otherwise.
//  - Covers the write-then-read-next-cycle window of the synchronous-read RF.
//  Immediate:
//  - Long-imm register rLimm/rLimm_Valid loads when iLimm_Valid & iAdvance.
//  - rLimm_Valid clears on the next iAdvance without iLimm_Valid.
//  - Operand B = rLimm_Valid ? {rLimm, iImm[IMM_W-1:0]} : iImm when iSelect_Imm, else the bypass.
//  - Back-to-back prefixes: the last prefix wins.
//  - A prefix is not consumed while oStall=1.
//  - RSUBI (iIs_SUB & iSelect_Imm) swaps operands 0 and 1. Ports >=2 are never swapped.
//  Interlock FSM:
//  - States: IDLE, STALL.
//  - hazard = any port matches a source whose iSrc_Ready=0, and that match is the first-priority one.
//  - IDLE -> STALL on hazard. STALL -> IDLE when hazard deasserts.
//  - oStall = hazard (combinational, same cycle) in either state.
//  - 3-bit stall counter: increments in STALL, saturates at STALL_MAX, cleared in IDLE.
//  - oStall_Timeout sets when the counter reaches STALL_MAX while hazard=1.
//  - oStall_Timeout clears only on reset.
//  - iAdvance asserted together with oStall=1 is ignored; no state updates.
//  Reset values:
//  - FSM=IDLE, counter=0, shadow valid=0, rLimm=0, rLimm_Valid=0, oStall_Timeout=0.
//  - oStall=0 unless a hazard is present.
//  - oOperand and oStore_Data follow their inputs combinationally.
//  Reset mid-stall: returns to IDLE the next cycle; a pending prefix is discarded.
//  Latency:
//  - Operands and oStall: 0 cycles.
//  - Shadow and long-imm: visible the cycle after capture.
// TESTING
//  1. src0 and src2 both write r5 (0x11 / 0x22), read r5 on port 0 -> 0x11. Same test with addr 0 -> iRF_Data.
//  2. src2 writes r7=0xABCD; next cycle no source matches, iRF_Data stale 0 -> port 0 returns 0xABCD from the shadow.
//  3. Prefix 0x1234 then an ADDI with imm 0x5678 -> operand B 0x12345678. Following ADDI -> sign-extended imm only.
//  4. RSUBI r3=10, imm 3 -> oOperand0=3, oOperand1=10. oStore_Data=10.
//  5. src0 load to r4 with Ready=0 for 2 cycles, read r4 -> oStall=1 for 2 cycles. Ready=1 -> forwarded data, FSM IDLE.
//  6. Ready held 0 for 8 cycles -> oStall_Timeout rises on the cycle the counter hits 7 and stays set. Reset clears it.

Source files
------------

// File: rtl/cp_bypass_net.sv
// Operand bypass network: forwards write-back data from NUM_SRC pipeline stages to NUM_RD read
// ports, with a retire shadow, a long-immediate prefix register and a load-use interlock.
module cp_bypass_net #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 5,
    parameter int NUM_SRC   = 3,
    parameter int NUM_RD    = 2,
    parameter int IMM_W     = 16,
    parameter int STALL_MAX = 7
) (
    input  logic                      iClk,
    input  logic                      iReset,
    input  logic [NUM_SRC*ADDR_W-1:0] iSrc_Addr,
    input  logic [NUM_SRC*DATA_W-1:0] iSrc_Data,
    input  logic [NUM_SRC-1:0]        iSrc_Write_Enable,
    input  logic [NUM_SRC-1:0]        iSrc_Ready,
    input  logic [NUM_RD*ADDR_W-1:0]  iRd_Addr,
    input  logic [NUM_RD*DATA_W-1:0]  iRF_Data,
    input  logic                      iSelect_Imm,
    input  logic [DATA_W-1:0]         iImm,
    input  logic                      iLimm_Valid,
    input  logic [DATA_W-IMM_W-1:0]   iLimm_Value,
    input  logic                      iIs_SUB,
    input  logic                      iAdvance,
    output logic [NUM_RD*DATA_W-1:0]  oOperand,
    output logic [DATA_W-1:0]         oStore_Data,
    output logic                      oStall,
    output logic                      oStall_Timeout
);

    typedef enum logic {IDLE, STALL} state_t;

    state_t                    state_q, state_d;
    logic [2:0]                cnt_q, cnt_d;
    logic                      timeout_q, timeout_d;
    logic                      shadow_valid_q, shadow_valid_d;
    logic [ADDR_W-1:0]         shadow_addr_q;
    logic [DATA_W-1:0]         shadow_data_q;
    logic [DATA_W-IMM_W-1:0]   limm_q, limm_d;
    logic                      limm_valid_q, limm_valid_d;

    logic [DATA_W-1:0]         byp [NUM_RD];
    logic [NUM_RD-1:0]         port_hazard;
    logic                      hazard;
    logic                      advance_ok;
    logic [DATA_W-1:0]         imm_b;
    logic [DATA_W-1:0]         opb;
    logic                      rsubi;

    // Sources are scanned oldest to youngest so the youngest match overrides the rest.
    always_comb begin
        for (int p = 0; p < NUM_RD; p++) begin
            // NOTE: every combinational output gets a default first so no latch is inferred.
            byp[p]         = iRF_Data[p*DATA_W +: DATA_W];
            port_hazard[p] = 1'b0;
            if (shadow_valid_q && shadow_addr_q == iRd_Addr[p*ADDR_W +: ADDR_W])
                byp[p] = shadow_data_q;
            for (int s = NUM_SRC - 1; s >= 0; s--) begin
                if (iSrc_Write_Enable[s] && iRd_Addr[p*ADDR_W +: ADDR_W] != '0 &&
                    iRd_Addr[p*ADDR_W +: ADDR_W] == iSrc_Addr[s*ADDR_W +: ADDR_W]) begin
                    byp[p]         = iSrc_Data[s*DATA_W +: DATA_W];
                    port_hazard[p] = ~iSrc_Ready[s];
                end
            end
        end
    end

    assign hazard     = |port_hazard;
    assign advance_ok = iAdvance & ~hazard;
    assign imm_b      = limm_valid_q ? {limm_q, iImm[IMM_W-1:0]} : iImm;
    assign opb        = iSelect_Imm ? imm_b : byp[1];
    assign rsubi      = iIs_SUB & iSelect_Imm;

    always_comb begin
        for (int p = 0; p < NUM_RD; p++)
            oOperand[p*DATA_W +: DATA_W] = byp[p];
        oOperand[0 +: DATA_W]      = rsubi ? opb : byp[0];
        oOperand[DATA_W +: DATA_W] = rsubi ? byp[0] : opb;
    end

    assign oStore_Data    = byp[1];
    assign oStall         = hazard;
    assign oStall_Timeout = timeout_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                cnt_d = 3'd0;
                if (hazard) state_d = STALL;
            end
            STALL: begin
                if (!hazard) begin
                    state_d = IDLE;
                    cnt_d   = 3'd0;
                end else if (cnt_q != 3'(STALL_MAX)) begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            default: state_d = IDLE;
        endcase
        timeout_d      = timeout_q | (hazard && cnt_d == 3'(STALL_MAX));
        limm_d         = (advance_ok && iLimm_Valid) ? iLimm_Value : limm_q;
        limm_valid_d   = advance_ok ? iLimm_Valid : limm_valid_q;
        shadow_valid_d = iSrc_Write_Enable[NUM_SRC-1] &&
                         iSrc_Addr[(NUM_SRC-1)*ADDR_W +: ADDR_W] != '0;
    end

    // NOTE: shadow addr/data are not reset; the valid bit alone gates their use.
    always_ff @(posedge iClk) begin
        shadow_addr_q <= iSrc_Addr[(NUM_SRC-1)*ADDR_W +: ADDR_W];
        shadow_data_q <= iSrc_Data[(NUM_SRC-1)*DATA_W +: DATA_W];
        if (iReset) begin
            // NOTE: state is updated with non-blocking assignments so every register sees pre-edge values.
            state_q        <= IDLE;
            cnt_q          <= 3'd0;
            timeout_q      <= 1'b0;
            shadow_valid_q <= 1'b0;
            limm_q         <= '0;
            limm_valid_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            timeout_q      <= timeout_d;
            shadow_valid_q <= shadow_valid_d;
            limm_q         <= limm_d;
            limm_valid_q   <= limm_valid_d;
        end
    end

endmodule

// File: tb/tb_cp_bypass_net.sv
// Randomised and directed bench for cp_bypass_net against a cycle-level behavioural model.
module tb_cp_bypass_net;

    localparam int STALL_MAX = 7;

    logic        iClk = 1'b0;
    logic        iReset;
    logic [4:0]  src_addr [3];
    logic [31:0] src_data [3];
    logic        src_we   [3];
    logic        src_rdy  [3];
    logic [4:0]  rd_addr  [2];
    logic [31:0] rf_data  [2];
    logic        sel_imm, limm_valid, is_sub, advance;
    logic [31:0] imm;
    logic [15:0] limm_value;

    logic [14:0] iSrc_Addr;
    logic [95:0] iSrc_Data;
    logic [2:0]  iSrc_Write_Enable, iSrc_Ready;
    logic [9:0]  iRd_Addr;
    logic [63:0] iRF_Data;
    logic [63:0] oOperand;
    logic [31:0] oStore_Data;
    logic        oStall, oStall_Timeout;

    assign iSrc_Addr         = {src_addr[2], src_addr[1], src_addr[0]};
    assign iSrc_Data         = {src_data[2], src_data[1], src_data[0]};
    assign iSrc_Write_Enable = {src_we[2], src_we[1], src_we[0]};
    assign iSrc_Ready        = {src_rdy[2], src_rdy[1], src_rdy[0]};
    assign iRd_Addr          = {rd_addr[1], rd_addr[0]};
    assign iRF_Data          = {rf_data[1], rf_data[0]};

    cp_bypass_net dut (
        .iClk(iClk), .iReset(iReset),
        .iSrc_Addr(iSrc_Addr), .iSrc_Data(iSrc_Data),
        .iSrc_Write_Enable(iSrc_Write_Enable), .iSrc_Ready(iSrc_Ready),
        .iRd_Addr(iRd_Addr), .iRF_Data(iRF_Data),
        .iSelect_Imm(sel_imm), .iImm(imm),
        .iLimm_Valid(limm_valid), .iLimm_Value(limm_value),
        .iIs_SUB(is_sub), .iAdvance(advance),
        .oOperand(oOperand), .oStore_Data(oStore_Data),
        .oStall(oStall), .oStall_Timeout(oStall_Timeout)
    );

    always #5 iClk = ~iClk;

    int n_checks = 0;
    int n_errors = 0;

    // Model state: last retired write, pending prefix, run length of consecutive stalled cycles.
    logic        m_sh_v = 1'b0;
    logic [4:0]  m_sh_a = '0;
    logic [31:0] m_sh_d = '0;
    logic        m_limm_v = 1'b0;
    logic [15:0] m_limm = '0;
    int          m_streak = 0;
    logic        m_to = 1'b0;

    logic [31:0] obs_op0, obs_op1, obs_store;
    logic        obs_stall, obs_to;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic clear_inputs();
        for (int i = 0; i < 3; i++) begin
            src_addr[i] = '0; src_data[i] = '0; src_we[i] = 1'b0; src_rdy[i] = 1'b1;
        end
        for (int i = 0; i < 2; i++) begin
            rd_addr[i] = '0; rf_data[i] = '0;
        end
        sel_imm = 0; limm_valid = 0; is_sub = 0; advance = 0; imm = '0; limm_value = '0;
        iReset = 0;
    endtask

    task automatic cycle(input bit chk);
        logic [31:0] fw [2];
        logic [31:0] opb, e0, e1;
        logic        hz, found;
        @(negedge iClk);
        hz = 1'b0;
        for (int p = 0; p < 2; p++) begin
            found = 1'b0;
            fw[p] = rf_data[p];
            for (int s = 0; s < 3; s++) begin
                if (!found && src_we[s] && rd_addr[p] != 0 && src_addr[s] == rd_addr[p]) begin
                    found = 1'b1;
                    fw[p] = src_data[s];
                    if (!src_rdy[s]) hz = 1'b1;
                end
            end
            if (!found && m_sh_v && m_sh_a == rd_addr[p]) fw[p] = m_sh_d;
        end
        opb = sel_imm ? (m_limm_v ? {m_limm, imm[15:0]} : imm) : fw[1];
        e0  = (is_sub && sel_imm) ? opb : fw[0];
        e1  = (is_sub && sel_imm) ? fw[0] : opb;
        obs_op0 = oOperand[31:0]; obs_op1 = oOperand[63:32];
        obs_store = oStore_Data; obs_stall = oStall; obs_to = oStall_Timeout;
        if (chk) begin
            check("operand0", obs_op0, e0);
            check("operand1", obs_op1, e1);
            check("store_data", obs_store, fw[1]);
            check("stall", obs_stall, hz);
            check("timeout", obs_to, m_to);
        end
        @(posedge iClk);
        if (iReset) begin
            m_sh_v = 0; m_limm_v = 0; m_limm = '0; m_streak = 0; m_to = 0;
        end else begin
            m_sh_v = src_we[2] && src_addr[2] != 0;
            m_sh_a = src_addr[2];
            m_sh_d = src_data[2];
            if (advance && !hz) begin
                m_limm_v = limm_valid;
                if (limm_valid) m_limm = limm_value;
            end
            m_streak = hz ? m_streak + 1 : 0;
            if (m_streak >= STALL_MAX + 1) m_to = 1'b1;
        end
        #1;
    endtask

    initial begin
        clear_inputs();
        iReset = 1;
        cycle(0);
        cycle(1);
        iReset = 0;
        rf_data[0] = 32'h0000_BEEF;
        cycle(1);
        check("rst_stall", obs_stall, 1'b0);
        check("rst_timeout", obs_to, 1'b0);
        check("rst_op0_rf", obs_op0, 32'h0000_BEEF);

        // Youngest source wins; register 0 is never forwarded.
        src_we[0] = 1; src_addr[0] = 5; src_data[0] = 32'h11;
        src_we[2] = 1; src_addr[2] = 5; src_data[2] = 32'h22;
        rd_addr[0] = 5; rf_data[0] = 32'hDEAD;
        cycle(1);
        check("t1_youngest", obs_op0, 32'h11);
        src_addr[0] = 0; src_addr[2] = 0; rd_addr[0] = 0;
        cycle(1);
        check("t1_r0_rf", obs_op0, 32'hDEAD);

        // Retire shadow covers the synchronous-read window.
        clear_inputs();
        src_we[2] = 1; src_addr[2] = 7; src_data[2] = 32'hABCD; rd_addr[0] = 1;
        cycle(1);
        clear_inputs();
        rd_addr[0] = 7;
        cycle(1);
        check("t2_shadow", obs_op0, 32'hABCD);

        // Long-immediate prefix, then plain immediate.
        clear_inputs();
        limm_valid = 1; limm_value = 16'h1234; advance = 1;
        cycle(1);
        limm_valid = 0; sel_imm = 1; imm = 32'h0000_5678;
        cycle(1);
        check("t3_limm", obs_op1, 32'h1234_5678);
        imm = 32'hFFFF_9ABC;
        cycle(1);
        check("t3_short_imm", obs_op1, 32'hFFFF_9ABC);

        // RSUBI swap.
        clear_inputs();
        src_we[0] = 1; src_addr[0] = 3; src_data[0] = 32'd10;
        rd_addr[0] = 3; rd_addr[1] = 3; sel_imm = 1; is_sub = 1; imm = 32'd3; advance = 1;
        cycle(1);
        check("t4_op0", obs_op0, 32'd3);
        check("t4_op1", obs_op1, 32'd10);
        check("t4_store", obs_store, 32'd10);

        // Load-use interlock; a prefix offered during the stall is not taken.
        clear_inputs();
        src_we[0] = 1; src_addr[0] = 4; src_data[0] = 32'h44; src_rdy[0] = 0; rd_addr[0] = 4;
        advance = 1; limm_valid = 1; limm_value = 16'hBEEF;
        for (int i = 0; i < 2; i++) begin
            cycle(1);
            check("t5_stall", obs_stall, 1'b1);
        end
        src_rdy[0] = 1; limm_valid = 0; advance = 0;
        cycle(1);
        check("t5_release", obs_stall, 1'b0);
        check("t5_fwd", obs_op0, 32'h44);
        clear_inputs();
        sel_imm = 1; imm = 32'd1; advance = 1;
        cycle(1);
        check("t5_no_prefix", obs_op1, 32'd1);

        // Timeout after a long stall; sticky until reset.
        clear_inputs();
        src_we[0] = 1; src_addr[0] = 4; src_rdy[0] = 0; rd_addr[0] = 4;
        for (int i = 0; i < 8; i++) begin
            cycle(1);
            check("t6_to_low", obs_to, 1'b0);
        end
        src_rdy[0] = 1;
        cycle(1);
        check("t6_to_set", obs_to, 1'b1);
        cycle(1);
        check("t6_to_sticky", obs_to, 1'b1);
        iReset = 1;
        cycle(1);
        iReset = 0;
        cycle(1);
        check("t6_to_cleared", obs_to, 1'b0);

        // Random traffic.
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < 3; i++) begin
                src_addr[i] = 5'($urandom_range(0, 7));
                src_data[i] = $urandom;
                src_we[i]   = 1'($urandom_range(0, 1));
                src_rdy[i]  = ($urandom_range(0, 7) != 0);
            end
            for (int i = 0; i < 2; i++) begin
                rd_addr[i] = 5'($urandom_range(0, 7));
                rf_data[i] = $urandom;
            end
            sel_imm    = 1'($urandom_range(0, 1));
            is_sub     = 1'($urandom_range(0, 1));
            advance    = 1'($urandom_range(0, 1));
            limm_valid = ($urandom_range(0, 3) == 0);
            limm_value = 16'($urandom);
            imm        = $urandom;
            iReset     = ($urandom_range(0, 63) == 0);
            cycle(1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
